fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 129 ++++++++++++
 tb/tb_fetch_stage.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage with a single outstanding imem request, a
// one-entry stall buffer and redirect flushing into the IF/ID register.
//
// Ports:
//   clk, rstn          clock, async active-low reset
//   npc, redirect      redirect target and strobe from next-PC unit
//   stall              hazard-unit hold of IF/ID
//   imem_req/addr      fetch request pulse and address (== pc)
//   imem_rvalid/rdata  instruction memory response
//   pc                 current fetch PC
//   id_pc/inst/valid   IF/ID register
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] npc,
  input  logic        redirect,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] idpc_q, idpc_d;
  logic [31:0] idinst_q, idinst_d;
  logic        idv_q, idv_d;
  logic [31:0] pc_tgt;
  logic [31:0] pc_inc;

  assign pc_tgt = {npc[31:2], 2'b00};
  assign pc_inc = pc_q + 32'd4;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    buf_d    = buf_q;
    idpc_d   = idpc_q;
    idinst_d = idinst_q;
    // no write this cycle: bubble unless held
    idv_d    = stall ? idv_q : 1'b0;
    unique case (state_q)
      S_REQ: begin
        state_d = redirect ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (redirect) begin
            state_d = S_REQ;
          end else if (stall) begin
            buf_d   = imem_rdata;
            state_d = S_HOLD;
          end else begin
            idinst_d = imem_rdata;
            idpc_d   = pc_q;
            idv_d    = 1'b1;
            pc_d     = pc_inc;
            state_d  = S_REQ;
          end
        end else if (redirect) begin
          // response still in flight: swallow it
          state_d = S_DROP;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          state_d = S_REQ;
        end else if (!stall) begin
          idinst_d = buf_q;
          idpc_d   = pc_q;
          idv_d    = 1'b1;
          pc_d     = pc_inc;
          state_d  = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rvalid) state_d = S_REQ;
      end
    endcase
    if (redirect) begin
      pc_d  = pc_tgt;
      idv_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
      buf_q    <= '0;
      idpc_q   <= '0;
      idinst_q <= NOP;
      idv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      buf_q    <= buf_d;
      idpc_q   <= idpc_d;
      idinst_q <= idinst_d;
      idv_q    <= idv_d;
    end
  end

  // gated by rstn so no request escapes while reset is held
  assign imem_req  = rstn & (state_q == S_REQ);
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign id_pc     = idpc_q;
  assign id_inst   = idinst_q;
  assign id_valid  = idv_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: fetch_stage bench with a latency-queue memory and a
// transaction-level model of the fetch stream.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] npc;
  logic        redirect;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk),
    .rstn(rstn),
    .npc(npc),
    .redirect(redirect),
    .stall(stall),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .pc(pc),
    .id_pc(id_pc),
    .id_inst(id_inst),
    .id_valid(id_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
    int          tag;
  } rsp_t;

  rsp_t        q[$];
  int          now;
  int          epoch;
  int          lat_fix;
  int          n_chk;
  int          n_fail;
  int          n_commit;
  logic [31:0] m_pc;
  logic [31:0] m_idpc;
  logic [31:0] m_idinst;
  logic [31:0] abuf;
  logic        m_valid;
  logic        avail;
  logic        req;
  logic [31:0] addr;

  function automatic logic [31:0] mw(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0033;
  endfunction

  // One clock: drive inputs, sample request, advance memory and model.
  task automatic cyc(input logic st, input logic rd,
                     input logic [31:0] np,
                     output logic rq, output logic [31:0] ra);
    logic        rv;
    logic [31:0] rdat;
    int          rtag;
    logic        good;
    int          due;
    rsp_t        r;
    while (q.size() > 0 && q[0].due < now) void'(q.pop_front());
    rv = 1'b0;
    if (q.size() > 0) rv = (q[0].due == now);
    rdat = $urandom;
    rtag = -1;
    if (rv) begin
      rdat = q[0].data;
      rtag = q[0].tag;
    end
    stall       = st;
    redirect    = rd;
    npc         = np;
    imem_rvalid = rv;
    imem_rdata  = rdat;
    #1;
    rq = imem_req;
    ra = imem_addr;
    @(posedge clk);
    if (rv) void'(q.pop_front());
    if (rstn) begin
      if (rq) begin
        due = now + ((lat_fix > 0) ? lat_fix : int'($urandom_range(1, 4)));
        if (q.size() > 0 && due <= q[$].due) due = q[$].due + 1;
        r.due  = due;
        r.data = mw(ra);
        r.tag  = epoch;
        q.push_back(r);
      end
      good = rv && (rtag == epoch);
      if (rd) begin
        m_valid = 1'b0;
        m_pc    = {np[31:2], 2'b00};
        avail   = 1'b0;
        epoch++;
      end else if (st) begin
        if (good) begin
          avail = 1'b1;
          abuf  = rdat;
        end
      end else if (avail || good) begin
        m_valid  = 1'b1;
        m_idpc   = m_pc;
        m_idinst = avail ? abuf : rdat;
        m_pc     = m_pc + 32'd4;
        avail    = 1'b0;
        n_commit++;
      end else begin
        m_valid = 1'b0;
      end
    end
    now++;
    @(negedge clk);
    stall       = 1'b0;
    redirect    = 1'b0;
    imem_rvalid = 1'b0;
  endtask

  task automatic model_reset(input bit keep_q);
    m_pc     = RST_PC;
    m_valid  = 1'b0;
    m_idpc   = '0;
    m_idinst = NOP;
    avail    = 1'b0;
    abuf     = '0;
    epoch++;
    if (!keep_q) q.delete();
  endtask

  task automatic do_reset(input bit keep_q);
    rstn = 1'b0;
    #1;
    model_reset(keep_q);
    cyc(1'b0, 1'b0, 32'h0, req, addr);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    lat_fix = 1;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 32'h0, req, addr);
    rstn = 1'b0;
    #1;
    model_reset(1'b0);
    n_chk++;
    if (pc !== RST_PC) begin
      n_fail++;
      $display("FAIL rst_pc: got %h want %h", pc, RST_PC);
    end
    n_chk++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_req: got %b want 0", imem_req);
    end
    n_chk++;
    if ({id_valid, id_pc, id_inst} !== {1'b0, 32'h0, NOP}) begin
      n_fail++;
      $display("FAIL rst_ifid: got %b %h %h want 0 0 %h",
               id_valid, id_pc, id_inst, NOP);
    end
    cyc(1'b0, 1'b0, 32'h0, req, addr);
    n_chk++;
    if ({imem_req, pc} !== {1'b0, RST_PC}) begin
      n_fail++;
      $display("FAIL rst_held: got %b %h want 0 %h", imem_req, pc, RST_PC);
    end
    rstn = 1'b1;
    #1;
    n_chk++;
    if ({imem_req, imem_addr} !== {1'b1, RST_PC}) begin
      n_fail++;
      $display("FAIL rst_first_req: got %b %h want 1 %h",
               imem_req, imem_addr, RST_PC);
    end
  endtask

  task automatic test_reset_release();
    logic [31:0] e;
    do_reset(1'b0);
    lat_fix = 1;
    for (int i = 0; i < 6; i++) begin
      e = 32'(i / 2) * 32'd4;
      cyc(1'b0, 1'b0, 32'h0, req, addr);
      if (i % 2 == 0) begin
        n_chk++;
        if ({req, addr, id_valid} !== {1'b1, e, 1'b0}) begin
          n_fail++;
          $display("FAIL seq_req%0d: got %b %h v%b want 1 %h v0",
                   i, req, addr, id_valid, e);
        end
      end else begin
        n_chk++;
        if ({req, id_valid, id_pc, id_inst} !== {1'b0, 1'b1, e, mw(e)}) begin
          n_fail++;
          $display("FAIL seq_ifid%0d: got %b %b %h %h want 0 1 %h %h",
                   i, req, id_valid, id_pc, id_inst, e, mw(e));
        end
      end
    end
  endtask

  task automatic test_stall_hold();
    do_reset(1'b0);
    lat_fix = 1;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 32'h0, req, addr);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 32'h0, req, addr);
      n_chk++;
      if ({id_pc, id_valid, req} !== {32'h4, m_valid, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_hold%0d: got %h %b %b want 4 %b 0",
                 k, id_pc, id_valid, req, m_valid);
      end
    end
    cyc(1'b0, 1'b0, 32'h0, req, addr);
    n_chk++;
    if ({id_valid, id_pc, id_inst, pc} !== {1'b1, 32'h8, mw(32'h8), 32'hC}) begin
      n_fail++;
      $display("FAIL stall_release: got %b %h %h %h want 1 8 %h c",
               id_valid, id_pc, id_inst, pc, mw(32'h8));
    end
    cyc(1'b0, 1'b0, 32'h0, req, addr);
    n_chk++;
    if ({req, addr} !== {1'b1, 32'hC}) begin
      n_fail++;
      $display("FAIL stall_next_req: got %b %h want 1 c", req, addr);
    end
  endtask

  task automatic test_redirect_wait();
    bit seen;
    do_reset(1'b0);
    lat_fix = 1;
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 32'h0, req, addr);
    lat_fix = 3;
    cyc(1'b0, 1'b0, 32'h0, req, addr);
    n_chk++;
    if ({req, addr} !== {1'b1, 32'h10}) begin
      n_fail++;
      $display("FAIL redir_setup: got %b %h want 1 10", req, addr);
    end
    lat_fix = 1;
    cyc(1'b0, 1'b1, 32'h100, req, addr);
    n_chk++;
    if ({id_valid, pc, id_pc} !== {1'b0, 32'h100, 32'hC}) begin
      n_fail++;
      $display("FAIL redir_flush: got %b %h %h want 0 100 c",
               id_valid, pc, id_pc);
    end
    seen = 0;
    for (int k = 0; k < 8 && !seen; k++) begin
      cyc(1'b0, 1'b0, 32'h0, req, addr);
      if (req) begin
        seen = 1;
        n_chk++;
        if (addr !== 32'h100) begin
          n_fail++;
          $display("FAIL redir_target: got %h want 100", addr);
        end
      end else begin
        n_chk++;
        if (id_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL redir_drop: got id_valid %b id_pc %h want 0",
                   id_valid, id_pc);
        end
      end
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL redir_timeout: got no request want request at 100");
    end
    cyc(1'b0, 1'b0, 32'h0, req, addr);
    n_chk++;
    if ({id_valid, id_pc, id_inst} !== {1'b1, 32'h100, mw(32'h100)}) begin
      n_fail++;
      $display("FAIL redir_commit: got %b %h %h want 1 100 %h",
               id_valid, id_pc, id_inst, mw(32'h100));
    end
  endtask

  task automatic test_redirect_rvalid_stall();
    do_reset(1'b0);
    lat_fix = 1;
    cyc(1'b0, 1'b0, 32'h0, req, addr);
    cyc(1'b1, 1'b1, 32'h203, req, addr);
    n_chk++;
    if ({id_valid, pc, id_pc, id_inst} !== {1'b0, 32'h200, 32'h0, NOP}) begin
      n_fail++;
      $display("FAIL rstall_flush: got %b %h %h %h want 0 200 0 %h",
               id_valid, pc, id_pc, id_inst, NOP);
    end
    cyc(1'b0, 1'b0, 32'h0, req, addr);
    n_chk++;
    if ({req, addr} !== {1'b1, 32'h200}) begin
      n_fail++;
      $display("FAIL rstall_req: got %b %h want 1 200", req, addr);
    end
  endtask

  task automatic test_wrap();
    do_reset(1'b0);
    lat_fix = 1;
    cyc(1'b0, 1'b0, 32'h0, req, addr);
    cyc(1'b0, 1'b1, 32'hFFFF_FFFC, req, addr);
    cyc(1'b0, 1'b0, 32'h0, req, addr);
    n_chk++;
    if ({req, addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      n_fail++;
      $display("FAIL wrap_req: got %b %h want 1 fffffffc", req, addr);
    end
    cyc(1'b0, 1'b0, 32'h0, req, addr);
    n_chk++;
    if ({id_valid, id_pc, id_inst, pc} !==
        {1'b1, 32'hFFFF_FFFC, mw(32'hFFFF_FFFC), 32'h0}) begin
      n_fail++;
      $display("FAIL wrap_commit: got %b %h %h pc %h want 1 fffffffc %h 0",
               id_valid, id_pc, id_inst, pc, mw(32'hFFFF_FFFC));
    end
    cyc(1'b0, 1'b0, 32'h0, req, addr);
    n_chk++;
    if ({req, addr} !== {1'b1, 32'h0}) begin
      n_fail++;
      $display("FAIL wrap_next: got %b %h want 1 0", req, addr);
    end
  endtask

  task automatic test_reset_midwait();
    do_reset(1'b0);
    lat_fix = 2;
    cyc(1'b0, 1'b0, 32'h0, req, addr);
    do_reset(1'b1);
    cyc(1'b0, 1'b0, 32'h0, req, addr);
    n_chk++;
    if ({req, addr, id_valid} !== {1'b1, RST_PC, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_restart: got %b %h v%b want 1 %h v0",
               req, addr, id_valid, RST_PC);
    end
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 1'b0, 32'h0, req, addr);
      n_chk++;
      if ({id_valid, id_pc, id_inst, pc} !==
          {m_valid, m_idpc, m_idinst, m_pc}) begin
        n_fail++;
        $display("FAIL midrst_run%0d: got %b %h %h %h want %b %h %h %h",
                 k, id_valid, id_pc, id_inst, pc,
                 m_valid, m_idpc, m_idinst, m_pc);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] e;
    int          c0;
    do_reset(1'b0);
    lat_fix = 0;
    c0 = n_commit;
    for (int i = 0; i < 800; i++) begin
      e = m_pc;
      cyc($urandom_range(0, 9) < 3, $urandom_range(0, 99) < 7,
          $urandom, req, addr);
      if (req) begin
        n_chk++;
        if (addr !== e) begin
          n_fail++;
          $display("FAIL rnd_req%0d: got %h want %h", i, addr, e);
        end
      end
      n_chk++;
      if ({id_valid, id_pc, id_inst, pc} !==
          {m_valid, m_idpc, m_idinst, m_pc}) begin
        n_fail++;
        $display("FAIL rnd_state%0d: got %b %h %h %h want %b %h %h %h",
                 i, id_valid, id_pc, id_inst, pc,
                 m_valid, m_idpc, m_idinst, m_pc);
      end
      if (id_valid === 1'b1) begin
        n_chk++;
        if (id_inst !== mw(id_pc)) begin
          n_fail++;
          $display("FAIL rnd_word%0d: got %h want %h",
                   i, id_inst, mw(id_pc));
        end
      end
    end
    n_chk++;
    if (n_commit - c0 < 40) begin
      n_fail++;
      $display("FAIL rnd_progress: got %0d commits want >= 40",
               n_commit - c0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn        = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    npc         = '0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    now         = 0;
    epoch       = 0;
    lat_fix     = 1;
    n_chk       = 0;
    n_fail      = 0;
    n_commit    = 0;
    model_reset(1'b0);
    @(negedge clk);
    test_reset();
    test_reset_release();
    test_stall_hold();
    test_redirect_wait();
    test_redirect_rvalid_stall();
    test_wrap();
    test_reset_midwait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
